cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Round-robin arbiter that shares one downstream cbus port, the PMP-checked memory path, between several upstream requesters such as instruction fetch and data memory access. It grants one requester at a time and holds the grant for the whole transaction, including every beat of a burst. It routes the downstream response back to the granted requester only, and rotates priority after each completed transaction.

## Interface
- NUM_PORTS, 2, number of upstream requesters (2..8); port 0 is the fetch side by convention.
- IDX_W, $clog2(NUM_PORTS), width of the grant index.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: sampled on clk, state clears when reset==0.
- ireqs  in  NUM_PORTS x cbus_req_t  upstream requests.
- iresps  out  NUM_PORTS x cbus_resp_t  upstream responses.
- oreq  out  cbus_req_t  downstream request to the PMP port.
- oresp  in  cbus_resp_t  downstream response.
- busy  out  1  high while a grant is held.
- grant_idx  out  IDX_W  index of the current or last granted port.

## Operation
- Two states, IDLE and BUSY, in a registered FSM.
- IDLE:
  - If any ireqs[i].valid is set, pick the winner and go to BUSY on the next edge.
  - The winner is the first valid port found scanning upward from (last+1) mod NUM_PORTS, wrapping around.
  - Register the winner in grant_idx.
- BUSY:
  - oreq = ireqs[grant_idx], passed through combinationally, so request fields may change between beats.
  - iresps[grant_idx] = oresp.
  - Every other iresps[j] is all-zero (ready=0, last=0, data=0).
- Completion is oresp.ready && oresp.last in BUSY.
  - Next state is IDLE.
  - last <= grant_idx.
- While not BUSY, oreq is all-zero (valid=0) and every iresps is all-zero.
- The grant is held until completion even if the granted requester drops valid mid-transaction. oreq then shows valid=0 and the arbiter waits; no timeout.
- New requests from other ports during BUSY are ignored until IDLE; nothing is queued.
- Priority pointer `last` resets to NUM_PORTS-1, so port 0 wins the first contention.
- A non-last oresp.ready beat is forwarded without leaving BUSY (burst).

## Timing
- Reset (reset==0 at an edge) gives:
  - state=IDLE, last=NUM_PORTS-1, grant_idx=0, busy=0;
  - oreq all-zero, all iresps all-zero.
- Reset mid-transaction aborts the grant. oreq.valid drops in the cycle after the reset edge and the downstream response is discarded.
- Grant latency: a request valid in IDLE at edge N gives busy=1 and oreq.valid=1 from cycle N+1, so there is 1 cycle of arbitration overhead.
- Response path: oresp to iresps has zero latency (combinational).
- The completion beat is delivered in the same cycle it arrives; busy=0 from the next cycle.
- Back-to-back: after a completion at edge M, the next grant is decided in IDLE at M+1 and oreq.valid rises at M+2. There is always at least one idle cycle between transactions.
- A new request arriving in the same cycle as a completion is not granted in that cycle; it is evaluated in IDLE.
- busy equals (state==BUSY) and is registered.

## Test plan
- Single request: ireqs[1].valid=1, addr=0x0800 with oresp.ready=last=1 held.
  - Cycle 1: busy=1, grant_idx=1, oreq.addr=0x0800.
  - Same cycle: iresps[1].ready=1, data=0xDEADBEEF; iresps[0].ready=0.
  - Next cycle: busy=0.
- Contention from reset: ports 0 and 1 both valid.
  - Port 0 is granted first.
  - After its completion, port 1 is granted with no further port 0 grant in between.
  - Port 0 then re-wins only after port 1 completes.
- Burst: grant port 0, then drive oresp.ready=1, last=0 for 3 beats, then last=1.
  - busy stays 1 for all 4 beats; port 1 sees ready=0 throughout.
  - busy=0 after the last beat.
- Mid-transaction drop: granted port drops valid before completion.
  - oreq.valid=0 and busy stays 1.
  - A request from another port is not granted until oresp.ready && last.
- Reset mid-BUSY: assert reset=0 for 1 cycle during a transaction.
  - Next cycle: busy=0, oreq.valid=0, grant_idx=0.
  - Subsequent contention grants port 0 first.
- Wrap-around with NUM_PORTS=4, all ports valid continuously: grant order 0,1,2,3,0.

Source files
------------

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one downstream cbus port among NUM_PORTS requesters.
// A grant is held from arbitration until the response beat flagged last is accepted.

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_PORTS],
    output cbus_resp_t       iresps [NUM_PORTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             done;

    // Scan from the farthest offset down so the nearest valid port after `last` wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (ireqs[(int'(last) + k) % NUM_PORTS].valid) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(last) + k) % NUM_PORTS);
            end
        end
    end

    assign done = oresp.ready && oresp.last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_PORTS - 1);
            grant_idx <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= BUSY;
                        grant_idx <= pick_idx;
                        busy      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state <= IDLE;
                        last  <= grant_idx;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Only the granted port is connected; everything else sees an all-zero bus.
    always_comb begin
        oreq = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            iresps[j] = '0;
        end
        if (busy) begin
            oreq              = ireqs[grant_idx];
            iresps[grant_idx] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter (4 ports): grant order is scoreboarded, bus
// routing and busy timing are checked inline.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int NUM = 4;
    localparam int IW  = 2;

    logic           clk;
    logic           reset;
    cbus_req_t      ireqs  [NUM];
    cbus_resp_t     iresps [NUM];
    cbus_req_t      oreq;
    cbus_resp_t     oresp;
    logic           busy;
    logic [IW-1:0]  grant_idx;

    int compared   = 0;
    int mismatched = 0;
    int expGrants[$];
    logic monPrev = 1'b0;

    cbus_arbiter #(.NUM_PORTS(NUM), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input logic v, input logic [31:0] a);
        ireqs[p].valid = v;
        ireqs[p].write = p[0];
        ireqs[p].be    = 4'hF;
        ireqs[p].addr  = a;
        ireqs[p].wdata = 32'hA000_0000 + p;
    endtask

    task automatic driveResp(input logic r, input logic l, input logic [31:0] d);
        oresp.ready = r;
        oresp.last  = l;
        oresp.data  = d;
    endtask

    task automatic dropAll();
        for (int p = 0; p < NUM; p++) applyStimulus(p, 1'b0, 32'h0);
    endtask

    task automatic waitGrants(input int n, input int budget, input string tag);
        int   seen = 0;
        logic prev = busy;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clk);
            if (busy && !prev) seen++;
            prev = busy;
        end
        checkOutput(tag, seen, n);
    endtask

    // Scoreboard: every rising busy must match the next expected grant index.
    always @(negedge clk) begin
        if (busy && !monPrev) begin
            automatic int e = (expGrants.size() > 0) ? expGrants.pop_front() : -1;
            checkOutput("grantOrder", grant_idx, e);
        end
        monPrev = busy;
    end

    initial begin
        reset = 1'b0;
        dropAll();
        driveResp(1'b1, 1'b1, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstGrantIdx", grant_idx, 2'd0);
        checkOutput("rstOreq", oreq, '0);
        for (int p = 0; p < NUM; p++) checkOutput("rstIresps", iresps[p], '0);

        // single request from port 1
        reset = 1'b1;
        applyStimulus(1, 1'b1, 32'h0000_0800);
        expGrants.push_back(1);
        @(negedge clk);
        checkOutput("singleBusy", busy, 1'b1);
        checkOutput("singleGrantIdx", grant_idx, 2'd1);
        checkOutput("singleAddr", oreq.addr, 32'h0000_0800);
        checkOutput("singleOreq", oreq, ireqs[1]);
        checkOutput("singleReady1", iresps[1].ready, 1'b1);
        checkOutput("singleData1", iresps[1].data, 32'hDEAD_BEEF);
        checkOutput("singleIdle0", iresps[0], '0);
        applyStimulus(1, 1'b0, 32'h0000_0800);
        @(negedge clk);
        checkOutput("singleDone", busy, 1'b0);
        checkOutput("singleOreqIdle", oreq.valid, 1'b0);
        checkOutput("singleRespIdle", iresps[1], '0);

        // contention from reset: 0, 1, 0
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 1'b1, 32'h100);
        applyStimulus(1, 1'b1, 32'h200);
        expGrants.push_back(0);
        expGrants.push_back(1);
        expGrants.push_back(0);
        waitGrants(3, 20, "contentionWait");
        dropAll();
        repeat (2) @(negedge clk);
        checkOutput("contentionIdle", busy, 1'b0);

        // burst on port 0 while port 1 waits
        driveResp(1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h300);
        expGrants.push_back(0);
        @(negedge clk);
        checkOutput("burstGrant", busy, 1'b1);
        applyStimulus(1, 1'b1, 32'h400);
        for (int b = 0; b < 3; b++) begin
            driveResp(1'b1, 1'b0, 32'hB000 + b);
            #1;
            checkOutput("burstData0", iresps[0].data, 32'hB000 + b);
            checkOutput("burstReady1", iresps[1].ready, 1'b0);
            @(negedge clk);
            checkOutput("burstHold", busy, 1'b1);
            checkOutput("burstIdx", grant_idx, 2'd0);
        end
        driveResp(1'b1, 1'b1, 32'hB0FF);
        #1;
        checkOutput("burstLast0", iresps[0].last, 1'b1);
        @(negedge clk);
        checkOutput("burstDone", busy, 1'b0);
        applyStimulus(0, 1'b0, 32'h0);
        expGrants.push_back(1);
        waitGrants(1, 5, "afterBurstWait");
        applyStimulus(1, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // granted port drops valid mid-transaction
        driveResp(1'b0, 1'b0, 32'h0);
        applyStimulus(2, 1'b1, 32'h500);
        expGrants.push_back(2);
        @(negedge clk);
        checkOutput("dropGrant", grant_idx, 2'd2);
        applyStimulus(2, 1'b0, 32'h500);
        applyStimulus(3, 1'b1, 32'h600);
        #1;
        checkOutput("dropOreqValid", oreq.valid, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("dropHoldBusy", busy, 1'b1);
            checkOutput("dropHoldIdx", grant_idx, 2'd2);
        end
        expGrants.push_back(3);
        driveResp(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("dropRelease", busy, 1'b0);
        waitGrants(1, 5, "dropNextWait");
        checkOutput("dropNextIdx", grant_idx, 2'd3);
        applyStimulus(3, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // reset while busy
        driveResp(1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b1, 32'h700);
        expGrants.push_back(1);
        @(negedge clk);
        checkOutput("rstMidGrant", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("rstMidBusy", busy, 1'b0);
        checkOutput("rstMidValid", oreq.valid, 1'b0);
        checkOutput("rstMidIdx", grant_idx, 2'd0);
        applyStimulus(0, 1'b1, 32'h800);
        driveResp(1'b1, 1'b1, 32'h0);
        expGrants.push_back(0);
        expGrants.push_back(1);
        waitGrants(2, 10, "rstMidWait");
        dropAll();
        repeat (2) @(negedge clk);

        // wrap-around with every port requesting
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < NUM; p++) applyStimulus(p, 1'b1, 32'h900 + p);
        foreach (expGrants[i]) expGrants.delete(i);
        expGrants.push_back(0);
        expGrants.push_back(1);
        expGrants.push_back(2);
        expGrants.push_back(3);
        expGrants.push_back(0);
        waitGrants(5, 30, "wrapWait");
        dropAll();
        repeat (3) @(negedge clk);
        checkOutput("sbDrain", expGrants.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
